// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving a 1-cycle-latency imem and
// buffering {pc, instr} in a small queue for decode.
module fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          QDEPTH     = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_csb0,
  output logic                  imem_web0,
  output logic [ADDR_WIDTH-1:0] imem_addr0,
  output logic [DATA_WIDTH-1:0] imem_din0,
  input  logic [DATA_WIDTH-1:0] imem_dout0,
  output logic                  if_valid,
  output logic [31:0]           if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  input  logic                  id_ready
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t                state, state_nxt;
  logic [31:0]           pc, req_pc;
  logic                  pending, issue, push, pop;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr, rd;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           q_pc    [QDEPTH];
  logic [DATA_WIDTH-1:0] q_instr [QDEPTH];

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;

  // An in-flight request reserves a queue slot, so a response push can never overflow.
  always_comb begin
    state_nxt  = (state == S_IDLE || fetch_en) ? S_RUN : S_HALT;
    issue      = state == S_RUN && fetch_en && !redirect_valid &&
                 (count + CW'(pending) < CW'(QDEPTH));
    imem_csb0  = !issue;
    imem_addr0 = issue ? pc[ADDR_WIDTH+1:2] : addr_q;
  end

  assign imem_web0 = 1'b1;
  assign imem_din0 = '0;
  assign if_valid  = count != '0;
  assign if_pc     = if_valid ? q_pc[rd] : '0;
  assign if_instr  = if_valid ? q_instr[rd] : '0;
  assign push      = pending && !redirect_valid;
  assign pop       = if_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc      <= RESET_PC;
      req_pc  <= '0;
      pending <= 1'b0;
      addr_q  <= '0;
      count   <= '0;
      wr      <= '0;
      rd      <= '0;
    end else if (redirect_valid) begin
      pc      <= redirect_pc & ~32'h3;
      pending <= 1'b0;
      count   <= '0;
      wr      <= '0;
      rd      <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
        addr_q <= pc[ADDR_WIDTH+1:2];
      end
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr]    <= req_pc;
      q_instr[wr] <= imem_dout0;
    end
endmodule
